// File: rtl/freq_sched_pkg.sv
// Shared types and constants for the two-voice frequency scheduler.
package freq_sched_pkg;
  localparam int FREQ_W   = 5;
  localparam int KEY_W    = 7;
  localparam int KEY_BASE = 48;
  localparam int NUM_FREQ = 32;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COMMIT, S_SETTLE} state_e;
endpackage

// File: rtl/freq_req_fifo.sv
// Small request queue; head is visible combinationally so the commit decision
// can be made in the same cycle that the frame edge is seen.
module freq_req_fifo #(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  parameter int W         = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [W-1:0]         din_i,
  input  logic                 pop_i,
  output logic [W-1:0]         dout_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [LOG_DEPTH:0]   count_o
);
  logic [W-1:0]         mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]   count_q;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (LOG_DEPTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/freq_scheduler.sv
// Arbitrates game/MIDI frequency requests into a queue and commits at most one
// voice change per video frame, on the cycle after the vsync rising edge.
module freq_scheduler
  import freq_sched_pkg::*;
#(
  parameter int                FIFO_DEPTH    = 4,
  parameter int                LOG_DEPTH     = 2,
  parameter int                SETTLE_CYCLES = 16,
  parameter logic [FREQ_W-1:0] INIT_ID1      = 5'd0,
  parameter logic [FREQ_W-1:0] INIT_ID2      = 5'd12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vsync_i,
  input  logic              game_valid_i,
  input  logic [FREQ_W-1:0] game_id_i,
  output logic              game_ready_o,
  input  logic              midi_ready_i,
  input  logic [KEY_W-1:0]  key_index_i,
  output logic [FREQ_W-1:0] freq_id1_o,
  output logic [FREQ_W-1:0] freq_id2_o,
  output logic              new_f_o,
  output logic [LOG_DEPTH:0] pending_o,
  output logic [7:0]        drop_count_o
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e            state_q;
  logic              vsync_q, vs_rise;
  logic [KEY_W-1:0]  key_off;
  logic              key_ok, midi_v, both, midi_win, game_win;
  logic              push, pop, full, empty, drop;
  logic [FREQ_W-1:0] push_id, head;
  logic [LOG_DEPTH:0] count;
  logic              rr_q, rr_d;
  logic [7:0]        drop_q, drop_d;
  logic [FREQ_W-1:0] id1_q, id2_q;
  logic              new_f_q, voice_q, head_dup;
  logic [SW-1:0]     settle_q;

  assign vs_rise = vsync_i & ~vsync_q;

  // The offset's upper bits double as the upper range check.
  assign key_off = key_index_i - KEY_W'(KEY_BASE);
  assign key_ok  = (key_index_i >= KEY_W'(KEY_BASE)) && (key_off < KEY_W'(NUM_FREQ));
  assign midi_v  = midi_ready_i & key_ok;
  assign both    = midi_v & game_valid_i;

  // rr_q == 0 favours midi; a full queue blocks both sides without a flip.
  assign midi_win     = midi_v & ~full & (~both | ~rr_q);
  assign game_win     = game_valid_i & ~full & ~(both & ~rr_q);
  assign game_ready_o = ~full & ~(both & ~rr_q);
  assign push         = midi_win | game_win;
  assign push_id      = midi_win ? key_off[FREQ_W-1:0] : game_id_i;
  assign drop         = midi_ready_i & ~midi_win;
  assign rr_d         = (both & ~full) ? ~rr_q : rr_q;
  assign drop_d       = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  assign pop      = (state_q == S_COMMIT);
  assign head_dup = (head == id1_q) || (head == id2_q);

  freq_req_fifo #(
    .DEPTH(FIFO_DEPTH), .LOG_DEPTH(LOG_DEPTH), .W(FREQ_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .din_i   (push_id),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= 1'b0;
      rr_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      vsync_q <= vsync_i;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  // Voice outputs are loaded on the ARMED->COMMIT edge so they and new_f
  // appear together in the COMMIT cycle; the entry is popped during COMMIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      id1_q    <= INIT_ID1;
      id2_q    <= INIT_ID2;
      new_f_q  <= 1'b0;
      voice_q  <= 1'b0;
      settle_q <= '0;
    end else begin
      new_f_q <= 1'b0;
      case (state_q)
        S_IDLE: if (count != '0) state_q <= S_ARMED;
        S_ARMED: begin
          if (vs_rise) begin
            state_q <= S_COMMIT;
            if (!head_dup) begin
              if (voice_q) id2_q <= head;
              else         id1_q <= head;
              new_f_q <= 1'b1;
              voice_q <= ~voice_q;
            end
          end
        end
        S_COMMIT: begin
          state_q  <= S_SETTLE;
          settle_q <= '0;
        end
        S_SETTLE: begin
          if (settle_q == SW'(SETTLE_CYCLES - 1))
            state_q <= (count != '0) ? S_ARMED : S_IDLE;
          else
            settle_q <= settle_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign freq_id1_o   = id1_q;
  assign freq_id2_o   = id2_q;
  assign new_f_o      = new_f_q;
  assign pending_o    = count;
  assign drop_count_o = drop_q;

  logic unused_ok;
  assign unused_ok = empty;
endmodule

// File: tb/tb_freq_scheduler.sv
// Scoreboard bench: expected voice pairs are queued as stimulus is driven and
// checked whenever the scheduler raises new_f.
module tb_freq_scheduler;
  localparam int SETTLE = 16;

  logic       clk = 1'b0, rst_n = 1'b0, vsync = 1'b0;
  logic       game_valid = 1'b0, midi_ready = 1'b0;
  logic [4:0] game_id = '0;
  logic [6:0] key_index = '0;
  logic       game_ready, new_f;
  logic [4:0] id1, id2;
  logic [2:0] pending;
  logic [7:0] drop_count;

  int         checks = 0, errors = 0, nf_cnt = 0, nf0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_e;
  logic [4:0] fill_ids[4] = '{5'd1, 5'd2, 5'd3, 5'd4};

  always #5 clk = ~clk;

  freq_scheduler dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .vsync_i      (vsync),
    .game_valid_i (game_valid),
    .game_id_i    (game_id),
    .game_ready_o (game_ready),
    .midi_ready_i (midi_ready),
    .key_index_i  (key_index),
    .freq_id1_o   (id1),
    .freq_id2_o   (id2),
    .new_f_o      (new_f),
    .pending_o    (pending),
    .drop_count_o (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    chk("sb_empty_before_reset", exp_q.size(), 0);
    rst_n = 1'b0; vsync = 1'b0; game_valid = 1'b0; midi_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic frame();
    vsync = 1'b1; tick();
    vsync = 1'b0;
    repeat (SETTLE + 6) tick();
  endtask

  task automatic midi(input logic [6:0] k);
    midi_ready = 1'b1; key_index = k; tick();
    midi_ready = 1'b0;
  endtask

  task automatic game(input logic [4:0] id);
    game_valid = 1'b1; game_id = id; tick();
    game_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && new_f) begin
      nf_cnt++;
      if (exp_q.size() == 0) chk("sb_commit_expected", exp_q.size(), 1);
      else begin
        exp_e = exp_q.pop_front();
        chk("sb_commit_ids", {id1, id2}, exp_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: request held through reset, commit one cycle after vsync rise
    game_valid = 1'b1; game_id = 5'd7;
    @(negedge clk);
    chk("rst_id1", id1, 0);
    chk("rst_id2", id2, 12);
    chk("rst_new_f", new_f, 0);
    chk("rst_pending", pending, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ready", game_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back({5'd7, 5'd12});
    tick(); game_valid = 1'b0;
    @(negedge clk); chk("t1_pending", pending, 1);
    tick(); tick();
    vsync = 1'b1;
    @(negedge clk); chk("t1_no_early_new_f", new_f, 0);
    tick(); vsync = 1'b0;
    @(negedge clk);
    chk("t1_new_f_latency", new_f, 1);
    chk("t1_id1", id1, 7);
    tick();
    @(negedge clk);
    chk("t1_new_f_single", new_f, 0);
    chk("t1_pending_drained", pending, 0);
    repeat (SETTLE + 4) tick();

    // 2: one in-range key, two out-of-range keys dropped
    do_reset();
    nf0 = nf_cnt;
    exp_q.push_back({5'd2, 5'd12});
    midi(7'd50); midi(7'd40); midi(7'd90);
    frame(); frame(); frame();
    chk("t2_drop", drop_count, 2);
    chk("t2_new_f_count", nf_cnt - nf0, 1);
    chk("t2_id1", id1, 2);

    // 3: simultaneous requests, midi wins first
    do_reset();
    exp_q.push_back({5'd5, 5'd12});
    exp_q.push_back({5'd5, 5'd9});
    midi_ready = 1'b1; key_index = 7'd53; game_valid = 1'b1; game_id = 5'd9;
    @(negedge clk); chk("t3_ready_lost", game_ready, 0);
    tick(); midi_ready = 1'b0;
    @(negedge clk); chk("t3_ready_next", game_ready, 1);
    tick(); game_valid = 1'b0;
    @(negedge clk); chk("t3_pending", pending, 2);
    frame(); frame();
    chk("t3_id1", id1, 5);
    chk("t3_id2", id2, 9);

    // 4: fill the queue, midi while full, pop frees space only afterwards
    do_reset();
    game_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      game_id = fill_ids[i];
      @(negedge clk); chk("t4_ready_fill", game_ready, 1);
      tick();
    end
    game_id = 5'd6;
    @(negedge clk);
    chk("t4_ready_full", game_ready, 0);
    chk("t4_pending_full", pending, 4);
    midi_ready = 1'b1; key_index = 7'd60;
    tick(); midi_ready = 1'b0;
    @(negedge clk);
    chk("t4_drop_full", drop_count, 1);
    chk("t4_pending_still_full", pending, 4);
    exp_q.push_back({5'd1, 5'd12});
    vsync = 1'b1; tick(); vsync = 1'b0;
    @(negedge clk);
    chk("t4_commit_pending", pending, 4);
    chk("t4_commit_ready", game_ready, 0);
    tick();
    @(negedge clk);
    chk("t4_ready_after_pop", game_ready, 1);
    chk("t4_pending_after_pop", pending, 3);
    tick(); game_valid = 1'b0;
    @(negedge clk); chk("t4_pending_refill", pending, 4);

    // 5: duplicate id pops silently, pointer stays on voice 0
    do_reset();
    nf0 = nf_cnt;
    game(5'd12);
    tick();
    frame();
    chk("t5_new_f_none", nf_cnt - nf0, 0);
    chk("t5_pending", pending, 0);
    chk("t5_id1", id1, 0);
    chk("t5_id2", id2, 12);
    exp_q.push_back({5'd3, 5'd12});
    game(5'd3);
    tick();
    frame();
    chk("t5_pointer_voice0", id1, 3);

    // 6: reset asserted in the commit cycle
    do_reset();
    nf0 = nf_cnt;
    game(5'd20);
    tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("t6_in_commit", new_f, 1);
    rst_n = 1'b0; #1;
    chk("t6_async_new_f", new_f, 0);
    chk("t6_id1", id1, 0);
    chk("t6_id2", id2, 12);
    chk("t6_pending", pending, 0);
    tick(); rst_n = 1'b1; tick();
    frame();
    chk("t6_no_new_f_after", nf_cnt - nf0, 0);

    // 7: drop counter saturation
    do_reset();
    midi_ready = 1'b1; key_index = 7'd10;
    repeat (260) tick();
    midi_ready = 1'b0;
    @(negedge clk); chk("t7_drop_sat", drop_count, 255);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_scheduler.md
Name: freq_scheduler

Overview:
- Sequences all wave-frequency changes into the physics block's two-voice frequency interface (freq_id1, freq_id2, new_f_in).
- Arbitrates between two requesters:
  - the game FSM (valid/ready handshake, 5-bit id);
  - the MIDI receiver (ready strobe plus 7-bit key index, cannot stall).
- Queues requests, assigns them alternately to the two voices, and commits at most one change per video frame, aligned to the rising edge of vsync.

Parameters:
- KEY_BASE, 48: MIDI key mapping to freq id 0; id = key - KEY_BASE.
- NUM_FREQ, 32: number of valid freq ids; 5-bit ids.
- FIFO_DEPTH, 4: request queue depth; power of two.
- LOG_DEPTH, 2: log2(FIFO_DEPTH).
- SETTLE_CYCLES, 16: dead cycles after each commit before the next commit may be armed.
- INIT_ID1, 5'd0: freq_id1 value after reset.
- INIT_ID2, 5'd12: freq_id2 value after reset.

Ports:
- clock, in, 1: 65 MHz system clock.
- reset, in, 1: asynchronous, active-low; block is held in reset while 0.
- vsync, in, 1: active-high vertical sync from the VGA timing generator.
- game_valid, in, 1: game FSM frequency request.
- game_id, in, 5: requested freq id.
- game_ready, out, 1: request accepted when game_valid & game_ready.
- midi_ready, in, 1: one-cycle strobe; key_index is valid in the same cycle.
- key_index, in, 7: MIDI key number.
- freq_id1, out, 5: voice 0 frequency id to physics.
- freq_id2, out, 5: voice 1 frequency id to physics.
- new_f, out, 1: one-cycle pulse; freq_id1/freq_id2 changed this cycle.
- pending, out, LOG_DEPTH+1: queue occupancy.
- drop_count, out, 8: saturating count of discarded requests.

Behaviour:
- Reset values:
  - freq_id1=INIT_ID1, freq_id2=INIT_ID2.
  - new_f=0, pending=0, drop_count=0, game_ready=1.
  - Voice pointer = 0; round-robin pointer favours midi; state IDLE.
  - Reset assertion mid-commit clears new_f immediately (asynchronously).
- Vsync edge detect: vsync is registered once; vs_rise = vsync & ~vsync_q.
- Mapping:
  - A midi strobe with key_index < KEY_BASE or key_index >= KEY_BASE+NUM_FREQ is discarded and drop_count increments.
  - In-range keys map to id = key_index - KEY_BASE, computed in 7 bits and truncated to 5.
- Arbitration (one push per cycle):
  - Only one requester present: it is pushed.
  - Both present in the same cycle: round-robin; the winner is pushed and the pointer flips.
  - A losing midi strobe is discarded and counted.
  - A losing game request stays pending, because game_ready=0 that cycle.
- Full queue:
  - game_ready = ~full, based on the registered occupancy at the start of the cycle.
  - A midi strobe arriving while full is discarded and counted.
  - A pop in the same cycle does not free space for a push in that cycle.
- drop_count saturates at 255. Two drops in one cycle are not possible.
- State machine:
  - IDLE: pending==0. Go to ARMED when pending>0.
  - ARMED: wait for vs_rise, then go to COMMIT.
  - COMMIT (one cycle): pop the head entry.
    - If the id equals the current id of the voice selected by the pointer, or of the other voice: no change, new_f stays 0, pointer unchanged.
    - Otherwise write the id to the voice selected by the pointer, drive new_f=1 for exactly this cycle, and toggle the pointer.
    - Go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to ARMED if pending>0, else IDLE.
- Timing:
  - Latency is vs_rise cycle + 1: outputs and new_f both change in the COMMIT cycle.
  - Maximum commit rate is one per frame.
- A vs_rise that arrives during SETTLE or IDLE is ignored. The request then waits for the next frame.
- freq_id1 and freq_id2 are registered and never change outside COMMIT.

Decomposition:
- Shared package freq_sched_pkg holds:
  - state encoding (IDLE, ARMED, COMMIT, SETTLE);
  - FREQ_W=5, KEY_W=7, KEY_BASE, NUM_FREQ.
- One sub-module: freq_req_fifo.
  - Synchronous FIFO: FIFO_DEPTH x 5 bits, wrap-around read/write pointers of LOG_DEPTH bits.
  - Outputs full, empty and count.
  - Asynchronous active-low reset on the pointers.
- Arbiter, key mapping, drop counter and FSM live in freq_scheduler.

Test Plan:
1. Reset with game_valid=1, game_id=7, then drive a vsync pulse.
   - Commit happens exactly 1 cycle after the vsync rise: freq_id1=7, freq_id2=12, a single-cycle new_f, pending returns to 0.
2. midi strobes for keys 50, 40 and 90 in separate cycles, with 3 vsync pulses.
   - Key 50 commits id 2 to voice 0.
   - Keys 40 and 90 are dropped: drop_count=2.
   - Only one new_f pulse in total.
3. Simultaneous midi key 53 and game id 9 after reset.
   - midi wins: id 5 is queued.
   - game_ready=0 that cycle, and id 9 is accepted on the next cycle.
   - Over 2 frames: freq_id1=5, then freq_id2=9.
4. Push 5 game ids with no vsync.
   - The 5th is held because game_ready=0 at pending=4.
   - A midi strobe while full sets drop_count=1.
   - The next vsync pops one entry, and game_ready returns to 1 after the pop.
5. Queue id 12 (equal to INIT_ID2), then a vsync.
   - Entry is popped, new_f stays 0, outputs are unchanged, pointer stays 0.
6. Assert reset (drive it to 0) in the COMMIT cycle.
   - new_f=0 immediately, outputs return to INIT values, pending=0.
   - After release, no new_f occurs on the next vsync.
